// File: rtl/sink_arb_pkg.sv
// Shared constants and state type for the sink round-robin arbiter.
package sink_arb_pkg;

  localparam int DEF_NUM_SINKS      = 64;
  localparam int DEF_LOG2_NUM_SINKS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sink_ffs_enc.sv
// Find-lowest-set-bit encoder; idx is 0 and found is 0 when vec is empty.
module sink_ffs_enc
  import sink_arb_pkg::*;
#(
  parameter int NUM_SINKS      = DEF_NUM_SINKS,
  parameter int LOG2_NUM_SINKS = DEF_LOG2_NUM_SINKS
) (
  input  logic [NUM_SINKS-1:0]      vec,
  output logic [LOG2_NUM_SINKS-1:0] idx,
  output logic                      found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_SINKS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = LOG2_NUM_SINKS'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sink_rr_arbiter.sv
// Round-robin arbiter driving the output mux select for NUM_SINKS sinks.
// Optional packet locking (no interleave across a packet) with SINK_ARB_LOCK_EN.
module sink_rr_arbiter
  import sink_arb_pkg::*;
#(
  parameter int NUM_SINKS      = DEF_NUM_SINKS,
  parameter int LOG2_NUM_SINKS = DEF_LOG2_NUM_SINKS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SINKS-1:0]      req,
  input  logic [NUM_SINKS-1:0]      last,
  input  logic                      out_ready,
  output logic                      gnt_valid,
  output logic [LOG2_NUM_SINKS-1:0] gnt_idx,
  output logic [NUM_SINKS-1:0]      gnt_onehot,
  output logic [NUM_SINKS-1:0]      ack
);

  localparam logic [LOG2_NUM_SINKS-1:0] PTR_RESET = LOG2_NUM_SINKS'(NUM_SINKS - 1);

  arb_state_e                state_reg;
  logic [LOG2_NUM_SINKS-1:0] ptr_reg;
  logic [LOG2_NUM_SINKS-1:0] gnt_idx_reg;
  logic [NUM_SINKS-1:0]      gnt_onehot_reg;
  logic                      gnt_valid_reg;

  logic [LOG2_NUM_SINKS-1:0] sel_ptr;
  logic [NUM_SINKS-1:0]      masked;
  logic [LOG2_NUM_SINKS-1:0] masked_idx;
  logic [LOG2_NUM_SINKS-1:0] req_idx;
  logic [LOG2_NUM_SINKS-1:0] win_idx;
  logic [NUM_SINKS-1:0]      win_onehot;
  logic                      masked_found;
  logic                      req_found;
  logic                      xfer;
  logic                      gnt_dropped;
  logic                      hold_lock;
  logic                      rearb;

  assign xfer        = gnt_valid_reg & out_ready;
  assign gnt_dropped = gnt_valid_reg & ~req[gnt_idx_reg];

  // On a transfer the mask already reflects the sink just served.
  assign sel_ptr = xfer ? gnt_idx_reg : ptr_reg;

  generate
    for (genvar gi = 0; gi < NUM_SINKS; gi++) begin : g_sink
      assign masked[gi]     = req[gi] & (gi > int'(sel_ptr));
      assign win_onehot[gi] = (int'(win_idx) == gi);
    end
  endgenerate

  sink_ffs_enc #(
    .NUM_SINKS      (NUM_SINKS),
    .LOG2_NUM_SINKS (LOG2_NUM_SINKS)
  ) u_enc_masked (
    .vec   (masked),
    .idx   (masked_idx),
    .found (masked_found)
  );

  sink_ffs_enc #(
    .NUM_SINKS      (NUM_SINKS),
    .LOG2_NUM_SINKS (LOG2_NUM_SINKS)
  ) u_enc_req (
    .vec   (req),
    .idx   (req_idx),
    .found (req_found)
  );

  assign win_idx = masked_found ? masked_idx : req_idx;

`ifdef SINK_ARB_LOCK_EN
  assign hold_lock = ~last[gnt_idx_reg];
`else
  logic unused_last;
  assign unused_last = ^last;
  assign hold_lock   = 1'b0;
`endif

  // A pending grant without out_ready is frozen unless its requester vanished.
  assign rearb = (state_reg == IDLE) | (xfer & ~hold_lock) | (~xfer & gnt_dropped);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= PTR_RESET;
      gnt_idx_reg    <= '0;
      gnt_onehot_reg <= '0;
      gnt_valid_reg  <= 1'b0;
    end else if (rearb) begin
      if (xfer) begin
        ptr_reg <= gnt_idx_reg;
      end
      if (req_found) begin
        state_reg      <= GRANT;
        gnt_valid_reg  <= 1'b1;
        gnt_idx_reg    <= win_idx;
        gnt_onehot_reg <= win_onehot;
      end else begin
        state_reg      <= IDLE;
        gnt_valid_reg  <= 1'b0;
        gnt_onehot_reg <= '0;
      end
`ifdef SINK_ARB_LOCK_EN
    end else if (xfer) begin
      state_reg <= LOCK;
`endif
    end
  end

  assign gnt_valid  = gnt_valid_reg;
  assign gnt_idx    = gnt_idx_reg;
  assign gnt_onehot = gnt_onehot_reg;
  assign ack        = out_ready ? gnt_onehot_reg : '0;

endmodule

// File: tb/tb_sink_rr_arbiter.sv
// Scoreboard bench for sink_rr_arbiter: stimulus pushes expected grant indices,
// a negedge monitor pops and checks on every transfer. Lock case needs SINK_ARB_LOCK_EN.
module tb_sink_rr_arbiter;

  localparam int N  = 64;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic          out_ready;
  logic          gnt_valid;
  logic [LW-1:0] gnt_idx;
  logic [N-1:0]  gnt_onehot;
  logic [N-1:0]  ack;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  sink_rr_arbiter #(.NUM_SINKS(N), .LOG2_NUM_SINKS(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .last       (last),
    .out_ready  (out_ready),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .ack        (ack)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per transfer, idle/wait cycles must not ack.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_xfer got idx=%0d expected none", gnt_idx);
        end else begin
          int e;
          logic [N-1:0] exp_oh;
          e = exp_q.pop_front();
          exp_oh = '0;
          exp_oh[e] = 1'b1;
          if (gnt_idx !== LW'(e) || ack !== exp_oh || gnt_onehot !== exp_oh) begin
            failures++;
            $display("FAIL xfer got idx=%0d ack=0x%0h expected idx=%0d ack=0x%0h",
                     gnt_idx, ack, e, exp_oh);
          end else begin
            $display("xfer idx=%0d ack=0x%0h", gnt_idx, ack);
          end
        end
      end else begin
        chk("no_ack_without_xfer", ack, '0);
        if (!gnt_valid) chk("onehot_zero_idle", gnt_onehot, '0);
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    rst = 1'b0; req = '0; last = '0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_valid", 64'(gnt_valid), 0);
    chk("reset_idx", 64'(gnt_idx), 0);
    chk("reset_onehot", gnt_onehot, 0);
    step(2);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_valid", 64'(gnt_valid), 0);
      chk("idle_ack", ack, 0);
    end

    // Rotation over {3,7,63}
    foreach (exp_q[i]) ;
    exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(63);
    exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(63);
    v = '0; v[3] = 1'b1; v[7] = 1'b1; v[63] = 1'b1;
    req = v; out_ready = 1'b1;
    step(6);
    req = '0;
    step(1);
    chk("rot_idle_after", 64'(gnt_valid), 0);

    // Sole requester 5, stalled for 4 cycles then acked twice
    out_ready = 1'b0;
    v = '0; v[5] = 1'b1; req = v;
    exp_q.push_back(5); exp_q.push_back(5);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_valid", 64'(gnt_valid), 1);
      chk("stall_idx", 64'(gnt_idx), 5);
    end
    out_ready = 1'b1;
    step(1);
    chk("regrant_idx", 64'(gnt_idx), 5);
    req = '0;
    step(1);
    out_ready = 1'b0;

    // Frozen grant on 2 while 9 arrives
    v = '0; v[2] = 1'b1; req = v;
    exp_q.push_back(2); exp_q.push_back(9);
    step(1);
    chk("frozen_idx0", 64'(gnt_idx), 2);
    v[9] = 1'b1; req = v;
    step(2);
    chk("frozen_idx1", 64'(gnt_idx), 2);
    out_ready = 1'b1;
    step(1);
    chk("after_ack_idx", 64'(gnt_idx), 9);
    req = '0;
    step(1);
    out_ready = 1'b0;

    // Granted sink 20 drops its request: release, pointer stays at 9
    v = '0; v[20] = 1'b1; req = v;
    step(1);
    chk("drop_pre_idx", 64'(gnt_idx), 20);
    v = '0; v[12] = 1'b1; v[30] = 1'b1; req = v;
    step(1);
    chk("drop_new_idx", 64'(gnt_idx), 12);
    exp_q.push_back(12);
    out_ready = 1'b1; req = '0;
    step(1);
    chk("drop_idle", 64'(gnt_valid), 0);

    // Fairness: all sinks requesting, pointer at 12
    for (int k = 0; k < N; k++) exp_q.push_back((13 + k) % N);
    req = '1;
    step(N);
    req = '0;
    step(1);
    out_ready = 1'b0;

    // Reset in the middle of a grant
    v = '0; v[40] = 1'b1; req = v;
    step(1);
    chk("pre_rst_idx", 64'(gnt_idx), 40);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_valid", 64'(gnt_valid), 0);
    chk("rst_idx", 64'(gnt_idx), 0);
    chk("rst_onehot", gnt_onehot, 0);
    chk("rst_ack", ack, 0);
    step(1);
    rst = 1'b0;
    v = '0; v[0] = 1'b1; v[1] = 1'b1; req = v;
    exp_q.push_back(0);
    step(1);
    chk("post_rst_idx", 64'(gnt_idx), 0);
    req = '0;
    step(1);
    out_ready = 1'b0;

`ifdef SINK_ARB_LOCK_EN
    // Three-beat packet from sink 1 while sink 4 waits
    v = '0; v[1] = 1'b1; v[4] = 1'b1; req = v;
    last = '0; out_ready = 1'b1;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(4);
    step(2);
    chk("lock_beat2_idx", 64'(gnt_idx), 1);
    step(1);
    last[1] = 1'b1;
    chk("lock_beat3_idx", 64'(gnt_idx), 1);
    step(1);
    chk("lock_next_idx", 64'(gnt_idx), 4);
    req = '0; last = '0;
    step(1);
    out_ready = 1'b0;
`endif

    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sink_rr_arbiter.md
# sink_rr_arbiter

Round-robin arbiter that shares the single interconnect output path between `NUM_SINKS` requesting sinks. Each cycle it picks one requester using a rotating-priority scheme built from two find-first-set encoders (masked and unmasked), registers the winner's index, and holds the grant until the output side accepts the transfer. It sits directly ahead of the output mux and drives its select.

## Interface
Parameters:
- `NUM_SINKS`, default 64: number of requesters.
- `LOG2_NUM_SINKS`, default 6: index width, equal to ceil(log2(`NUM_SINKS`)).

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req`, input, `NUM_SINKS`: per-sink request; bit i high means sink i has a beat.
- `last`, input, `NUM_SINKS`: per-sink end-of-packet flag for the current beat. Used only under `SINK_ARB_LOCK_EN`; ignored otherwise.
- `out_ready`, input, 1: output side accepts the granted beat this cycle.
- `gnt_valid`, output, 1: a grant is active.
- `gnt_idx`, output, `LOG2_NUM_SINKS`: index of the granted sink. Drives the output mux select.
- `gnt_onehot`, output, `NUM_SINKS`: one-hot form of `gnt_idx`; all zero when `gnt_valid` is 0.
- `ack`, output, `NUM_SINKS`: combinational; equals `gnt_onehot` when `out_ready` is high, otherwise all zero. One-hot or zero.

## Operation
- States:
  - IDLE: `gnt_valid` = 0.
  - GRANT: `gnt_valid` = 1.
  - LOCK: only under `SINK_ARB_LOCK_EN`; `gnt_valid` = 1.
- Pointer `ptr` (`LOG2_NUM_SINKS` bits) holds the index of the last sink that completed a transfer. Reset value is `NUM_SINKS`-1, so sink 0 has first priority.
- Selection:
  - `masked` = `req` with bits 0..`ptr` cleared.
  - The winner is the lowest set bit of `masked`.
  - If `masked` is zero, the winner is the lowest set bit of `req`.
- IDLE → GRANT: when `req` is nonzero, the winner is registered into `gnt_idx` and `gnt_valid` is set.
- In GRANT, the transfer cycle is the cycle with `gnt_valid` & `out_ready`. On that edge:
  - `ptr` is loaded with `gnt_idx`.
  - The next winner is chosen in the same cycle, using the updated mask, from the current `req`. If `req` is zero, the state goes to IDLE.
  - Back-to-back grants are allowed, giving one beat per cycle.
- Sole requester: if the just-served sink is the only one requesting, it is granted again.
- While a grant is pending without `out_ready`, `gnt_idx` is frozen and new or dropped requests from other sinks have no effect.
- Protocol rule: the granted sink must hold `req` until it sees `ack`. If the granted sink's `req` drops without `ack`:
  - the grant is released on the next edge;
  - `ptr` is not updated;
  - normal selection is performed.
- `NUM_SINKS` not a power of two: unused index values are never produced.

## Timing
- Request to grant: 1 cycle. `req` is sampled at edge n and `gnt_valid`/`gnt_idx` are valid after edge n.
- `ack` has 0-cycle latency from `out_ready`.
- All registered outputs come directly from flops.
- Reset values, asynchronous on `rst` rising:
  - `gnt_valid` = 0
  - `gnt_idx` = 0
  - `gnt_onehot` = 0
  - `ptr` = `NUM_SINKS`-1
  - state = IDLE
- Reset mid-grant drops the grant immediately. The beat is not acked.
- Fairness: with all sinks continuously requesting, each sink is granted exactly once every `NUM_SINKS` transfers.

## Configuration
- `SINK_ARB_LOCK_EN` defined:
  - A transfer with `last[gnt_idx]` = 0 moves to LOCK, or stays in LOCK.
  - In LOCK the grant is held on the same sink for subsequent beats, and `ptr` is not updated.
  - A transfer with `last[gnt_idx]` = 1 performs normal re-arbitration as in GRANT.
  - Packets from different sinks are never interleaved.
- `SINK_ARB_LOCK_EN` not defined:
  - The `last` port remains present but is unused.
  - The LOCK state is not synthesized.
  - Re-arbitration happens after every beat.

## Structure
- Shared package `sink_arb_pkg` holds:
  - `NUM_SINKS` and `LOG2_NUM_SINKS` default constants;
  - the state enum type (IDLE, GRANT, LOCK).
- Sub-module `sink_ffs_enc`: parameterized find-lowest-set-bit encoder.
  - Inputs: `NUM_SINKS` vector.
  - Outputs: index and a found flag; index is 0 when no bit is set.
  - Implemented as a loop, not a hand-written casez, so it tracks `NUM_SINKS`.
  - Instantiated twice, for `masked` and for `req`.

## Test plan
- Reset, then `req`=0x0 held for 10 cycles → `gnt_valid` stays 0 and `ack` stays 0.
- `req` bits {3,7,63} set continuously, `out_ready`=1 → `gnt_idx` sequence is 3,7,63,3,7,63. Each grant lasts 1 cycle.
- `req` bit 5 only, `out_ready`=0 for 4 cycles then 1 → `gnt_idx`=5 is held stable for 4 cycles, `ack[5]` pulses in cycle 5, then sink 5 is re-granted while `req[5]` stays high.
- Grant held on sink 2 with `out_ready`=0, `req[9]` then raised → `gnt_idx` stays 2. After the ack on sink 2, `gnt_idx`=9.
- `SINK_ARB_LOCK_EN`: sink 1 sends 3 beats with `last` on beat 3 while sink 4 requests → `gnt_idx` is 1,1,1, then 4.
- `rst` asserted while `gnt_valid`=1 → all outputs are 0 with no clock edge. After release, `req` bits {0,1} set → first grant is sink 0.
